// File: rtl/motion_estimator_if.sv
// Bus between the motion estimator and its surroundings: start/done control,
// the three combinational memory read ports, the result vector and FSM state.
//
// Handshake: start is a level request sampled while idle; done is a level that
// stays high, with motionx/motiony valid, until start has been seen low.
// Memory ports have no handshake: data must follow its address in the same cycle.
interface motion_estimator_if;
   logic       start;
   logic [7:0] R;
   logic [7:0] s1;
   logic [7:0] s2;
   logic [7:0] AddressR;
   logic [9:0] AddressS1;
   logic [9:0] AddressS2;
   logic [3:0] motionx;
   logic [3:0] motiony;
   logic       done;
   logic [1:0] state_dbg;

   modport master (
      output start, R, s1, s2,
      input  AddressR, AddressS1, AddressS2, motionx, motiony, done, state_dbg
   );

   modport slave (
      input  start, R, s1, s2,
      output AddressR, AddressS1, AddressS2, motionx, motiony, done, state_dbg
   );
endinterface

// File: rtl/motion_estimator.sv
// Full-search block matcher: 16x16 reference block against a 31x31 window.
// Sixteen PEs, PE k owning ox=k. The reference pixel stream is delayed k cycles
// into PE k, so all PEs consume the same window row position each cycle: s1
// supplies the current row (PEs with col >= k) and s2 the row 16 pixels earlier
// (PEs still finishing the previous reference row). The global pixel index runs
// continuously across all 16 oy values, so PEs finish in raster order, one per
// cycle, and a single strict-less-than comparator gives first-in-raster ties.
module motion_estimator (
   input logic            clock,
   input logic            reset_n,
   motion_estimator_if.slave bus
);

   typedef enum logic [1:0] {IDLE = 2'd0, COMPUTE = 2'd1, FLUSH = 2'd2, DONE = 2'd3} state_t;

   // Index 4095 (last pixel of oy=15) reaches PE 15 fifteen cycles late.
   localparam logic [12:0] LAST_T = 13'd4110;

   state_t      state, state_n;
   logic [12:0] t_cnt;
   logic [7:0]  r_sr [0:14];
   logic [15:0] sad_next [0:15];
   logic [3:0]  pe_oy [0:15];
   logic [15:0] pe_last;
   logic [3:0]  c;
   logic [4:0]  row1, row2;
   logic [7:0]  p_hi;
   logic        cand_hit, cand_valid, take;
   logic [15:0] cand_sad_n, cand_sad, best_sad;
   logic [3:0]  cand_ox_n, cand_oy_n, cand_ox, cand_oy, best_ox, best_oy;
   logic [3:0]  best_ox_n, best_oy_n;
   logic [3:0]  motionx_q, motiony_q;

   // State register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_n;
   end

   // Next-state logic; start is ignored outside IDLE and DONE.
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (bus.start) state_n = COMPUTE;
         COMPUTE: if (t_cnt == LAST_T) state_n = FLUSH;
         FLUSH:   state_n = DONE;
         DONE:    if (!bus.start) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Global pixel index: oy in [11:8], ref row in [7:4], ref col in [3:0].
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)                                 t_cnt <= '0;
      else if (state == IDLE)                       t_cnt <= '0;
      else if (state == COMPUTE && t_cnt != LAST_T) t_cnt <= t_cnt + 13'd1;
   end

   // Address generation; s2 points at the window row of pixel index t-16.
   always_comb begin
      c    = t_cnt[3:0];
      row1 = {1'b0, t_cnt[7:4]} + {1'b0, t_cnt[11:8]};
      p_hi = t_cnt[11:4] - 8'd1;
      row2 = {1'b0, p_hi[3:0]} + {1'b0, p_hi[7:4]};
      bus.AddressR  = '0;
      bus.AddressS1 = '0;
      bus.AddressS2 = '0;
      if (state == COMPUTE) begin
         bus.AddressR  = t_cnt[7:0];
         bus.AddressS1 = {5'd0, row1} * 10'd31 + {6'd0, c};
         // Column 31 would be outside the window; no PE uses s2 when c=15.
         if (c != 4'd15) bus.AddressS2 = {5'd0, row2} * 10'd31 + {6'd0, c} + 10'd16;
      end
   end

   // Reference pixel delay line feeding PE k with the pixel read k cycles ago.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 15; i++) r_sr[i] <= '0;
      end else begin
         r_sr[0] <= bus.R;
         for (int i = 1; i < 15; i++) r_sr[i] <= r_sr[i-1];
      end
   end

   for (genvar k = 0; k < 16; k++) begin : g_pe
      logic [12:0] tk;
      logic [7:0]  r_pix, s_pix, ad;
      logic [15:0] acc;
      logic        valid;

      // tk is the pixel index this PE works on; bit 12 flags before-start or past-end.
      assign tk    = t_cnt - 13'(k);
      assign valid = (state == COMPUTE) && !tk[12];

      if (k == 0) begin : g_first
         assign r_pix = bus.R;
         assign s_pix = bus.s1;
      end else begin : g_rest
         assign r_pix = r_sr[k-1];
         assign s_pix = (c >= 4'(k)) ? bus.s1 : bus.s2;
      end

      assign ad          = (r_pix >= s_pix) ? r_pix - s_pix : s_pix - r_pix;
      assign sad_next[k] = acc + {8'd0, ad};
      assign pe_last[k]  = valid && (tk[7:0] == 8'hFF);
      assign pe_oy[k]    = tk[11:8];

      // SAD accumulator; restarts after the last pixel of each oy.
      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n)           acc <= '0;
         else if (state == IDLE) acc <= '0;
         else if (valid)         acc <= pe_last[k] ? 16'd0 : sad_next[k];
      end
   end

   // Pick the single PE that completes a candidate this cycle.
   always_comb begin
      cand_hit   = 1'b0;
      cand_sad_n = '0;
      cand_ox_n  = '0;
      cand_oy_n  = '0;
      for (int k = 0; k < 16; k++) begin
         if (pe_last[k]) begin
            cand_hit   = 1'b1;
            cand_sad_n = sad_next[k];
            cand_ox_n  = 4'(k);
            cand_oy_n  = pe_oy[k];
         end
      end
   end

   // Candidate register between the PEs and the comparator.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cand_valid <= 1'b0;
         cand_sad   <= '0;
         cand_ox    <= '0;
         cand_oy    <= '0;
      end else begin
         cand_valid <= cand_hit;
         cand_sad   <= cand_sad_n;
         cand_ox    <= cand_ox_n;
         cand_oy    <= cand_oy_n;
      end
   end

   // Strict less-than keeps the earlier raster position on ties.
   always_comb begin
      take      = cand_valid && (cand_sad < best_sad);
      best_ox_n = take ? cand_ox : best_ox;
      best_oy_n = take ? cand_oy : best_oy;
   end

   // Running best; cleared when a new search is launched.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         best_sad <= 16'hFFFF;
         best_ox  <= '0;
         best_oy  <= '0;
      end else if (state == IDLE && bus.start) begin
         best_sad <= 16'hFFFF;
         best_ox  <= '0;
         best_oy  <= '0;
      end else if (take) begin
         best_sad <= cand_sad;
         best_ox  <= cand_ox;
         best_oy  <= cand_oy;
      end
   end

   // Result vector loaded only on the way into DONE; offset-8 is an MSB flip.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         motionx_q <= '0;
         motiony_q <= '0;
      end else if (state == FLUSH) begin
         motionx_q <= best_ox_n ^ 4'h8;
         motiony_q <= best_oy_n ^ 4'h8;
      end
   end

   assign bus.motionx   = motionx_q;
   assign bus.motiony   = motiony_q;
   assign bus.done      = (state == DONE);
   assign bus.state_dbg = state;

endmodule

// File: tb/tb_motion_estimator.sv
// Directed bench for motion_estimator: fills the reference and window memories
// with hand-analysed patterns and checks the resulting vector, done behaviour,
// reset behaviour and address bounds.
module tb_motion_estimator;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;

   motion_estimator_if bus ();

   motion_estimator dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // Clock/reset block.
   always #5 clock = ~clock;

   logic [7:0] ref_mem  [0:255];
   logic [7:0] srch_mem [0:960];

   // Combinational memories.
   assign bus.R  = ref_mem[bus.AddressR];
   assign bus.s1 = (bus.AddressS1 <= 10'd960) ? srch_mem[bus.AddressS1] : 8'h00;
   assign bus.s2 = (bus.AddressS2 <= 10'd960) ? srch_mem[bus.AddressS2] : 8'h00;

   int tests_run    = 0;
   int tests_failed = 0;
   int addr_errs    = 0;

   // Address bound monitor.
   always @(negedge clock) begin
      if (bus.AddressS1 > 10'd960 || bus.AddressS2 > 10'd960) addr_errs++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Window pixel = (16*row + col) mod 256: any shift of the match changes every pixel.
   task automatic fill_linear();
      for (int r = 0; r < 31; r++)
         for (int cc = 0; cc < 31; cc++)
            srch_mem[r*31+cc] = 8'(r*16 + cc);
   endtask

   task automatic fill_ref_from(input int ox, input int oy);
      for (int i = 0; i < 16; i++)
         for (int j = 0; j < 16; j++)
            ref_mem[i*16+j] = srch_mem[(i+oy)*31 + j + ox];
   endtask

   task automatic fill_const(input logic [7:0] rv, input logic [7:0] sv);
      for (int i = 0; i < 256; i++) ref_mem[i] = rv;
      for (int i = 0; i < 961; i++) srch_mem[i] = sv;
   endtask

   // Raise start and wait (bounded) for done; start is left high.
   task automatic run_search(input string tag, output logic seen, output int cycles);
      logic early;
      seen   = 1'b0;
      cycles = 0;
      early  = 1'b0;
      @(negedge clock);
      bus.start = 1'b1;
      @(posedge clock);
      while (!seen && cycles < 4150) begin
         @(posedge clock);
         cycles++;
         #1;
         if (cycles == 1) early = bus.done;
         if (bus.done) seen = 1'b1;
      end
      check({tag, "_done_cleared"}, 32'(early), 32'd0);
      check({tag, "_done_in_time"}, 32'(seen), 32'd1);
   endtask

   task automatic release_start();
      @(negedge clock);
      bus.start = 1'b0;
      repeat (3) @(posedge clock);
      #1;
   endtask

   logic seen;
   int   cyc;

   initial begin
      bus.start = 1'b0;
      fill_const(8'h00, 8'h00);
      repeat (3) @(posedge clock);
      #1;
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_mx", 32'(bus.motionx), 32'd0);
      check("rst_my", 32'(bus.motiony), 32'd0);
      check("rst_state", 32'(bus.state_dbg), 32'd0);
      check("rst_addr_s1", 32'(bus.AddressS1), 32'd0);
      check("rst_addr_r", 32'(bus.AddressR), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;

      // Unique exact match at ox=11, oy=6 -> (+3,-2).
      fill_linear();
      fill_ref_from(11, 6);
      run_search("t1", seen, cyc);
      check("t1_mx", 32'(bus.motionx), 32'h3);
      check("t1_my", 32'(bus.motiony), 32'hE);
      release_start();

      // Reset part-way through a search.
      @(negedge clock);
      bus.start = 1'b1;
      repeat (2000) @(posedge clock);
      #2;
      reset_n   = 1'b0;
      bus.start = 1'b0;
      #1;
      check("mid_rst_done", 32'(bus.done), 32'd0);
      check("mid_rst_mx", 32'(bus.motionx), 32'd0);
      check("mid_rst_my", 32'(bus.motiony), 32'd0);
      check("mid_rst_state", 32'(bus.state_dbg), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      run_search("t5", seen, cyc);
      check("t5_mx", 32'(bus.motionx), 32'h3);
      check("t5_my", 32'(bus.motiony), 32'hE);

      // start kept high after done: no restart, outputs stable.
      repeat (200) @(posedge clock);
      #1;
      check("t6_hold_done", 32'(bus.done), 32'd1);
      check("t6_hold_mx", 32'(bus.motionx), 32'h3);
      check("t6_hold_my", 32'(bus.motiony), 32'hE);
      release_start();
      check("t6_idle_done", 32'(bus.done), 32'd0);
      check("t6_idle_mx", 32'(bus.motionx), 32'h3);
      run_search("t6b", seen, cyc);
      check("t6b_mx", 32'(bus.motionx), 32'h3);
      check("t6b_my", 32'(bus.motiony), 32'hE);
      release_start();

      // All zero: every SAD ties, first raster candidate (-8,-8) wins.
      fill_const(8'h00, 8'h00);
      run_search("t2", seen, cyc);
      check("t2_mx", 32'(bus.motionx), 32'h8);
      check("t2_my", 32'(bus.motiony), 32'h8);
      release_start();

      // Match only at the far corner ox=15, oy=15 -> (+7,+7).
      fill_linear();
      fill_ref_from(15, 15);
      run_search("t3", seen, cyc);
      check("t3_mx", 32'(bus.motionx), 32'h7);
      check("t3_my", 32'(bus.motiony), 32'h7);
      release_start();

      // Reference all FF; window FF only where (0,0) lines up.
      fill_const(8'hFF, 8'h00);
      for (int r = 8; r < 24; r++)
         for (int cc = 8; cc < 24; cc++)
            srch_mem[r*31+cc] = 8'hFF;
      run_search("t4", seen, cyc);
      check("t4_mx", 32'(bus.motionx), 32'h0);
      check("t4_my", 32'(bus.motiony), 32'h0);
      release_start();

      check("addr_bound", 32'(addr_errs), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
